// File: rtl/sw_arbiter_if.sv
// Request/grant bundle between route computation, the switch arbiter and the crossbar.
// The master side presents flits and credits; the slave side (the arbiter) returns grants.
interface sw_arbiter_if #(
  parameter int NPORT = 5
);
  logic [NPORT-1:0]   req_valid;
  logic [3*NPORT-1:0] req_port;
  logic [NPORT-1:0]   req_head;
  logic [NPORT-1:0]   req_tail;
  logic [NPORT-1:0]   credit_avail;
  logic [NPORT-1:0]   grant;
  logic [NPORT-1:0]   out_valid;
  logic [3*NPORT-1:0] sel;
  logic [NPORT-1:0]   busy;

  modport master (
    output req_valid, req_port, req_head, req_tail, credit_avail,
    input  grant, out_valid, sel, busy
  );

  modport slave (
    input  req_valid, req_port, req_head, req_tail, credit_avail,
    output grant, out_valid, sel, busy
  );
endinterface

// File: rtl/sw_arbiter.sv
// Per-output round-robin switch arbiter with wormhole locking.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_IDLE   | output free; any head flit aimed at it may compete
//   ST_LOCKED | output owned by owner_q[o] until that packet's tail crosses
//
// Grants are combinational (zero latency); state, owner and pointer move
// only on a granted flit.
module sw_arbiter #(
  parameter int NPORT = 5
) (
  input  logic        clk,
  input  logic        reset,
  sw_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [2:0] LAST = 3'(NPORT - 1);

  state_e     state_q  [NPORT];
  state_e     state_d  [NPORT];
  logic [2:0] owner_q  [NPORT];
  logic [2:0] owner_d  [NPORT];
  logic [2:0] rr_ptr_q [NPORT];
  logic [2:0] rr_ptr_d [NPORT];

  logic [NPORT-1:0]   grant;
  logic [NPORT-1:0]   out_valid;
  logic [3*NPORT-1:0] sel;
  logic [NPORT-1:0]   busy;

  // Candidate vector is 8 wide so any 3-bit scan index stays in range.
  logic [7:0] cand;
  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;

  // Pointer advance wraps explicitly at NPORT-1; a plain 3-bit add would run to 5..7.
  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == LAST) ? 3'd0 : p + 3'd1;
  endfunction

  // Per-output candidate build, round-robin pick, grant decode and next state.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      state_d[o]  = state_q[o];
      owner_d[o]  = owner_q[o];
      rr_ptr_d[o] = rr_ptr_q[o];
    end
    grant     = '0;
    out_valid = '0;
    sel       = '0;
    busy      = '0;
    cand      = '0;
    found     = 1'b0;
    winner    = '0;
    idx       = '0;

    if (!reset) begin
      for (int o = 0; o < NPORT; o++) begin
        state_d[o]  = ST_IDLE;
        owner_d[o]  = '0;
        rr_ptr_d[o] = '0;
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        busy[o] = (state_q[o] == ST_LOCKED);

        cand = '0;
        for (int i = 0; i < NPORT; i++) begin
          cand[i] = bus.req_valid[i] && (bus.req_port[3*i +: 3] == 3'(o)) &&
                    ((state_q[o] == ST_IDLE) ? bus.req_head[i]
                                             : (!bus.req_head[i] && (owner_q[o] == 3'(i))));
        end

        found  = 1'b0;
        winner = '0;
        idx    = rr_ptr_q[o];
        for (int k = 0; k < NPORT; k++) begin
          if (!found && cand[idx]) begin
            found  = 1'b1;
            winner = idx;
          end
          idx = ptr_inc(idx);
        end

        if (found && bus.credit_avail[o]) begin
          out_valid[o]     = 1'b1;
          sel[3*o +: 3]    = winner;
          grant[winner]    = 1'b1;
          if (state_q[o] == ST_IDLE) begin
            if (bus.req_tail[winner]) begin
              rr_ptr_d[o] = ptr_inc(winner);
            end else begin
              state_d[o] = ST_LOCKED;
              owner_d[o] = winner;
            end
          end else if (bus.req_tail[winner]) begin
            state_d[o]  = ST_IDLE;
            rr_ptr_d[o] = ptr_inc(owner_q[o]);
          end
        end
      end
    end
  end

  // State, owner and pointer registers; reset is folded into the _d logic.
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    owner_q  <= owner_d;
    rr_ptr_q <= rr_ptr_d;
  end

  assign bus.grant     = grant;
  assign bus.out_valid = out_valid;
  assign bus.sel       = sel;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_sw_arbiter.sv
// Directed bench for sw_arbiter: a vector table for per-cycle scenarios plus
// hand-written multi-cycle sequences (wormhole, credit stall, wrap, reset).
module tb_sw_arbiter;
  localparam int NPORT = 5;

  logic clk = 1'b0;
  logic reset;

  sw_arbiter_if #(.NPORT(NPORT)) bus ();

  sw_arbiter #(.NPORT(NPORT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [4:0]  valid;
    logic [14:0] port;
    logic [4:0]  head;
    logic [4:0]  tail;
    logic [4:0]  credit;
    logic [4:0]  exp_grant;
    logic [4:0]  exp_ov;
    logic [14:0] exp_sel;
    logic [4:0]  exp_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [14:0] pp(input logic [2:0] p0, p1, p2, p3, p4);
    return {p4, p3, p2, p1, p0};
  endfunction

  function automatic vec_t mk(input string nm, input logic rst, input logic [4:0] v,
                              input logic [14:0] p, input logic [4:0] h, t, c, eg, eov,
                              input logic [14:0] es, input logic [4:0] eb);
    vec_t r;
    r.name = nm; r.rst = rst; r.valid = v; r.port = p; r.head = h; r.tail = t;
    r.credit = c; r.exp_grant = eg; r.exp_ov = eov; r.exp_sel = es; r.exp_busy = eb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic rst, input logic [4:0] v,
                      input logic [14:0] p, input logic [4:0] h, t, c, eg, eov,
                      input logic [14:0] es, input logic [4:0] eb);
    reset            = rst;
    bus.req_valid    = v;
    bus.req_port     = p;
    bus.req_head     = h;
    bus.req_tail     = t;
    bus.credit_avail = c;
    @(negedge clk);
    chk({nm, ".grant"},     15'(bus.grant),     15'(eg));
    chk({nm, ".out_valid"}, 15'(bus.out_valid), 15'(eov));
    chk({nm, ".sel"},       bus.sel,            es);
    chk({nm, ".busy"},      15'(bus.busy),      15'(eb));
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0]  ALL = 5'b11111;
  localparam logic [4:0]  NO  = 5'b00000;
  localparam logic [14:0] Z   = 15'h0;

  initial begin
    reset            = 1'b0;
    bus.req_valid    = '0;
    bus.req_port     = '0;
    bus.req_head     = '0;
    bus.req_tail     = '0;
    bus.credit_avail = '0;

    // reset with live requests, then single-flit contention on output 1
    tbl.push_back(mk("rst0", 0, 5'b00001, pp(1,0,0,0,0), 5'b00001, 5'b00001, ALL, NO, NO, Z, NO));
    tbl.push_back(mk("rst1", 0, 5'b00001, pp(1,0,0,0,0), 5'b00001, 5'b00001, ALL, NO, NO, Z, NO));
    tbl.push_back(mk("rr0", 1, 5'b01101, pp(1,0,1,1,0), 5'b01101, 5'b01101, ALL,
                     5'b00001, 5'b00010, pp(0,0,0,0,0), NO));
    tbl.push_back(mk("rr1", 1, 5'b01101, pp(1,0,1,1,0), 5'b01101, 5'b01101, ALL,
                     5'b00100, 5'b00010, pp(0,2,0,0,0), NO));
    tbl.push_back(mk("rr2", 1, 5'b01101, pp(1,0,1,1,0), 5'b01101, 5'b01101, ALL,
                     5'b01000, 5'b00010, pp(0,3,0,0,0), NO));
    tbl.push_back(mk("rr3", 1, 5'b01101, pp(1,0,1,1,0), 5'b01101, 5'b01101, ALL,
                     5'b00001, 5'b00010, pp(0,0,0,0,0), NO));
    tbl.push_back(mk("nocred", 1, 5'b00001, pp(1,0,0,0,0), 5'b00001, 5'b00001, 5'b11101,
                     NO, NO, Z, NO));
    // parallel outputs: 0->2, 1->3, 4->0 (output 0 pointer wraps 4+1 -> 0)
    tbl.push_back(mk("par", 1, 5'b10011, pp(2,3,0,0,0), 5'b10011, 5'b10011, ALL,
                     5'b10011, 5'b01101, pp(4,0,0,1,0), NO));
    // out-of-range destinations never match
    tbl.push_back(mk("port67", 1, 5'b01100, pp(0,0,6,7,0), 5'b01100, 5'b01100, ALL,
                     NO, NO, Z, NO));
    tbl.push_back(mk("port5", 1, 5'b00010, pp(0,5,0,0,0), 5'b00010, 5'b00010, ALL,
                     NO, NO, Z, NO));

    for (int n = 0; n < tbl.size(); n++) begin
      step(tbl[n].name, tbl[n].rst, tbl[n].valid, tbl[n].port, tbl[n].head, tbl[n].tail,
           tbl[n].credit, tbl[n].exp_grant, tbl[n].exp_ov, tbl[n].exp_sel, tbl[n].exp_busy);
    end

    // wormhole lock on output 4: prime rr_ptr[4]=1, then input 1 sends H,B,B,T vs input 0 head
    step("wh_pre", 1, 5'b00001, pp(4,0,0,0,0), 5'b00001, 5'b00001, ALL,
         5'b00001, 5'b10000, Z, NO);
    step("wh0", 1, 5'b00011, pp(4,4,0,0,0), 5'b00011, 5'b00001, ALL,
         5'b00010, 5'b10000, pp(0,0,0,0,1), NO);
    step("wh1", 1, 5'b00011, pp(4,4,0,0,0), 5'b00001, 5'b00001, ALL,
         5'b00010, 5'b10000, pp(0,0,0,0,1), 5'b10000);
    step("wh2", 1, 5'b00011, pp(4,4,0,0,0), 5'b00001, 5'b00001, ALL,
         5'b00010, 5'b10000, pp(0,0,0,0,1), 5'b10000);
    step("wh3", 1, 5'b00011, pp(4,4,0,0,0), 5'b00001, 5'b00011, ALL,
         5'b00010, 5'b10000, pp(0,0,0,0,1), 5'b10000);
    step("wh4", 1, 5'b00001, pp(4,0,0,0,0), 5'b00001, 5'b00001, ALL,
         5'b00001, 5'b10000, Z, NO);
    step("wh5", 1, 5'b00011, pp(4,4,0,0,0), 5'b00011, 5'b00011, ALL,
         5'b00010, 5'b10000, pp(0,0,0,0,1), NO);

    // credit stall: 3-flit packet 2->0, credit for output 0 missing for one cycle
    step("cs0", 1, 5'b00100, pp(0,0,0,0,0), 5'b00100, NO, ALL,
         5'b00100, 5'b00001, pp(2,0,0,0,0), NO);
    step("cs1", 1, 5'b00100, pp(0,0,0,0,0), NO, NO, 5'b11110,
         NO, NO, Z, 5'b00001);
    step("cs2", 1, 5'b00100, pp(0,0,0,0,0), NO, NO, ALL,
         5'b00100, 5'b00001, pp(2,0,0,0,0), 5'b00001);
    step("cs3", 1, 5'b00100, pp(0,0,0,0,0), NO, 5'b00100, ALL,
         5'b00100, 5'b00001, pp(2,0,0,0,0), 5'b00001);
    step("cs4", 1, NO, Z, NO, NO, ALL, NO, NO, Z, NO);

    // pointer wrap on output 3: set rr_ptr[3]=4, input 4 wins over 0, then scan restarts at 0
    step("wr_pre", 1, 5'b01000, pp(0,0,0,3,0), 5'b01000, 5'b01000, ALL,
         5'b01000, 5'b01000, pp(0,0,0,3,0), NO);
    step("wr0", 1, 5'b10001, pp(3,0,0,0,3), 5'b10001, 5'b10001, ALL,
         5'b10000, 5'b01000, pp(0,0,0,4,0), NO);
    step("wr1", 1, 5'b10100, pp(0,0,3,0,3), 5'b10100, 5'b10100, ALL,
         5'b00100, 5'b01000, pp(0,0,0,2,0), NO);

    // reset mid-packet: output 2 locked to input 3, reset drops the lock
    step("rm0", 1, 5'b01000, pp(0,0,0,2,0), 5'b01000, NO, ALL,
         5'b01000, 5'b00100, pp(0,0,3,0,0), NO);
    step("rm1", 1, 5'b01000, pp(0,0,0,2,0), NO, NO, ALL,
         5'b01000, 5'b00100, pp(0,0,3,0,0), 5'b00100);
    step("rm2", 0, 5'b01000, pp(0,0,0,2,0), NO, NO, ALL, NO, NO, Z, NO);
    step("rm3", 1, 5'b01000, pp(0,0,0,2,0), NO, NO, ALL, NO, NO, Z, NO);
    step("rm4", 1, 5'b01001, pp(2,0,0,2,0), 5'b00001, 5'b00001, ALL,
         5'b00001, 5'b00100, Z, NO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
